// File: rtl/data_mem_arbiter_pkg.sv
// rtl/data_mem_arbiter_pkg.sv - shared types, port indices and address check for the data memory arbiter
package data_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam int PORT_CPU = 0;
    localparam int PORT_DMA = 1;

    // A word address is usable only when aligned and inside the populated memory.
    function automatic logic addr_illegal(input logic [31:0] addr, input logic [31:0] mem_words);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= mem_words);
    endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - requester and data memory bundle seen by the arbiter
interface data_mem_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [31:0] req_addr0;
    logic [31:0] req_addr1;
    logic [31:0] req_wdata0;
    logic [31:0] req_wdata1;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    // Requester side plus the memory model.
    modport master (
        output req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1, mem_read_data,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata, mem_read, mem_write, mem_address,
               mem_write_data
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1, mem_read_data,
        output req_ready, rsp_valid, rsp_err, rsp_rdata, mem_read, mem_write, mem_address,
               mem_write_data
    );
endinterface

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
// rtl/data_mem_arbiter_rr_arbiter2.sv - two-way round-robin / fixed-priority grant decode
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       fixed_prio,
    output logic [1:0] gnt
);

    // On a tie the port that did not win last time gets the grant, unless port 0 is pinned.
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            if (fixed_prio || last_grant) begin
                gnt = 2'b01;
            end else begin
                gnt = 2'b10;
            end
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - shares the single-port data memory between CPU and DMA requesters
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int MEM_WORDS     = 4096,
    parameter int ACCESS_CYCLES = 1,
    parameter int FIXED_PRIO    = 0
) (
    input  logic                clk,
    input  logic                rst,
    data_mem_arbiter_if.slave   bus
);

    localparam int              CW       = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LOAD = CW'(ACCESS_CYCLES - 1);
    localparam logic [31:0]     WORDS    = 32'(MEM_WORDS);

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          last_grant;
    logic          own;
    logic          lat_write;
    logic          lat_err;
    logic [1:0]    rsp_valid_q;
    logic          rsp_err_q;
    logic [31:0]   rsp_rdata_q;
    logic          mem_read_q;
    logic          mem_write_q;
    logic [31:0]   mem_addr_q;
    logic [31:0]   mem_wdata_q;

    logic [1:0]    gnt;
    logic [1:0]    ready;
    logic          hs;
    logic          sel;
    logic          sel_write;
    logic          sel_err;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;

    rr_arbiter2 u_arb (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .fixed_prio (FIXED_PRIO != 0),
        .gnt        (gnt)
    );

    // The memory is busy in ACCESS, so no new request is accepted there.
    assign ready     = (state == ST_ACCESS) ? 2'b00 : gnt;
    assign hs        = |(bus.req_valid & ready);
    assign sel       = ready[PORT_DMA];
    assign sel_addr  = sel ? bus.req_addr1  : bus.req_addr0;
    assign sel_wdata = sel ? bus.req_wdata1 : bus.req_wdata0;
    assign sel_write = sel ? bus.req_write[PORT_DMA] : bus.req_write[PORT_CPU];
    assign sel_err   = addr_illegal(sel_addr, WORDS);

    // Request latch, wait-state counter, memory strobes and response register in one FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            last_grant  <= 1'b1;
            own         <= 1'b0;
            lat_write   <= 1'b0;
            lat_err     <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            rsp_valid_q <= 2'b00;
            case (state)
                ST_IDLE, ST_RESP: begin
                    if (hs) begin
                        state       <= ST_ACCESS;
                        wait_cnt    <= CNT_LOAD;
                        last_grant  <= sel;
                        own         <= sel;
                        lat_write   <= sel_write;
                        lat_err     <= sel_err;
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_wdata;
                        mem_read_q  <= !sel_write && !sel_err;
                        // With no wait states the only ACCESS cycle is also the write cycle.
                        mem_write_q <= sel_write && !sel_err && (ACCESS_CYCLES == 1);
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (wait_cnt == '0) begin
                        state       <= ST_RESP;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        rsp_valid_q <= own ? 2'b10 : 2'b01;
                        rsp_err_q   <= lat_err;
                        rsp_rdata_q <= (!lat_write && !lat_err) ? bus.mem_read_data : 32'd0;
                    end else begin
                        wait_cnt    <= wait_cnt - 1'b1;
                        // Raise the write strobe only for the last ACCESS cycle.
                        mem_write_q <= lat_write && !lat_err && (wait_cnt == CW'(1));
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready      = ready;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_err        = rsp_err_q;
    assign bus.rsp_rdata      = rsp_rdata_q;
    assign bus.mem_read       = mem_read_q;
    assign bus.mem_write      = mem_write_q;
    assign bus.mem_address    = mem_addr_q;
    assign bus.mem_write_data = mem_wdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;
    import data_mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_arbiter_if ifa ();
    data_mem_arbiter_if ifb ();
    data_mem_arbiter_if ifc ();

    data_mem_arbiter #(.MEM_WORDS(4096), .ACCESS_CYCLES(1), .FIXED_PRIO(0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    data_mem_arbiter #(.MEM_WORDS(4096), .ACCESS_CYCLES(3), .FIXED_PRIO(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    data_mem_arbiter #(.MEM_WORDS(4096), .ACCESS_CYCLES(2), .FIXED_PRIO(0)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

    logic [31:0] mem_a [0:4095];
    logic [31:0] mem_b [0:4095];
    logic [31:0] mem_c [0:4095];

    assign ifa.mem_read_data = mem_a[ifa.mem_address[13:2]];
    assign ifb.mem_read_data = mem_b[ifb.mem_address[13:2]];
    assign ifc.mem_read_data = mem_c[ifc.mem_address[13:2]];

    // Memory models: one write per clock while the strobe is high.
    always @(posedge clk) begin
        if (ifa.mem_write) mem_a[ifa.mem_address[13:2]] <= ifa.mem_write_data;
        if (ifb.mem_write) mem_b[ifb.mem_address[13:2]] <= ifb.mem_write_data;
        if (ifc.mem_write) mem_c[ifc.mem_address[13:2]] <= ifc.mem_write_data;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]  rsp;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        int          port;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[10];
    int   last_port = 1;

    // Response scoreboard for dut_a and strobe exclusivity on every instance.
    always @(negedge clk) begin
        if (!rst) begin
            chk("strobe_excl_a", 32'(ifa.mem_read & ifa.mem_write), 32'd0);
            chk("strobe_excl_b", 32'(ifb.mem_read & ifb.mem_write), 32'd0);
            chk("strobe_excl_c", 32'(ifc.mem_read & ifc.mem_write), 32'd0);
            if (ifa.rsp_valid != 2'b00) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: rsp_valid=%b with no response expected", ifa.rsp_valid);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sb_rsp_valid", 32'(ifa.rsp_valid), 32'(mon_e.rsp));
                    chk("sb_rsp_err", 32'(ifa.rsp_err), 32'(mon_e.err));
                    chk("sb_rsp_rdata", ifa.rsp_rdata, mon_e.rdata);
                end
            end
        end
    end

    task automatic wait_sb_empty();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_timeout: %0d responses still outstanding", sb.size());
            sb.delete();
        end
    endtask

    task automatic drive_a(input int port, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            ifa.req_write[0] = wr;
            ifa.req_addr0    = addr;
            ifa.req_wdata0   = wdata;
        end else begin
            ifa.req_write[1] = wr;
            ifa.req_addr1    = addr;
            ifa.req_wdata1   = wdata;
        end
        ifa.req_valid[port] = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        drive_a(v.port, v.wr, v.addr, v.wdata);
        #1;
        chk("vec_ready", 32'(ifa.req_ready), (v.port == 1) ? 32'd2 : 32'd1);
        sb.push_back('{rsp: (v.port == 1) ? 2'b10 : 2'b01, err: v.err, rdata: v.rdata});
        last_port = v.port;
        @(posedge clk);
        #1;
        ifa.req_valid = 2'b00;
        @(negedge clk);
        chk("vec_mem_read", 32'(ifa.mem_read), 32'(!v.wr && !v.err));
        chk("vec_mem_write", 32'(ifa.mem_write), 32'(v.wr && !v.err));
        if (!v.err) chk("vec_mem_address", ifa.mem_address, v.addr);
        wait_sb_empty();
        if (v.wr && !v.err) chk("vec_mem_word", mem_a[v.addr[13:2]], v.wdata);
    endtask

    task automatic b_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output int rd_cnt, output int wr_cnt, output int wr_at, output int rsp_at,
                          output logic [31:0] rdata, output logic err);
        rd_cnt = 0; wr_cnt = 0; wr_at = 0; rsp_at = 0; rdata = '0; err = 1'b0;
        @(negedge clk);
        ifb.req_write[0] = wr;
        ifb.req_addr0    = addr;
        ifb.req_wdata0   = wdata;
        ifb.req_valid    = 2'b01;
        #1;
        chk("b_ready", 32'(ifb.req_ready), 32'd1);
        @(posedge clk);
        #1;
        ifb.req_valid = 2'b00;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (ifb.mem_read) rd_cnt++;
            if (ifb.mem_write) begin
                wr_cnt++;
                wr_at = c;
            end
            if (ifb.rsp_valid != 2'b00 && rsp_at == 0) begin
                rsp_at = c;
                rdata  = ifb.rsp_rdata;
                err    = ifb.rsp_err;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          exp_port;
        int          n;
        int          rd_cnt, wr_cnt, wr_at, rsp_at, rsp_seen;
        logic [31:0] rdata;
        logic        err;

        vecs[0] = '{0, 1'b1, 32'h0000_0008, 32'h0000_DEAD, 1'b0, 32'h0};
        vecs[1] = '{0, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'h0000_DEAD};
        vecs[2] = '{1, 1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0, 32'h0};
        vecs[3] = '{1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'h1234_5678};
        vecs[4] = '{1, 1'b0, 32'h0000_0006, 32'h0,         1'b1, 32'h0};
        vecs[5] = '{1, 1'b0, 32'h0000_4000, 32'h0,         1'b1, 32'h0};
        vecs[6] = '{0, 1'b1, 32'h0000_4000, 32'h0000_FFFF, 1'b1, 32'h0};
        vecs[7] = '{0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0};
        vecs[8] = '{1, 1'b1, 32'h0000_3FFC, 32'hA5A5_A5A5, 1'b0, 32'h0};
        vecs[9] = '{0, 1'b0, 32'h0000_3FFC, 32'h0,         1'b0, 32'hA5A5_A5A5};

        for (int i = 0; i < 4096; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
            mem_c[i] = '0;
        end
        ifa.req_valid = '0; ifa.req_write = '0; ifa.req_addr0 = '0; ifa.req_addr1 = '0;
        ifa.req_wdata0 = '0; ifa.req_wdata1 = '0;
        ifb.req_valid = '0; ifb.req_write = '0; ifb.req_addr0 = '0; ifb.req_addr1 = '0;
        ifb.req_wdata0 = '0; ifb.req_wdata1 = '0;
        ifc.req_valid = '0; ifc.req_write = '0; ifc.req_addr0 = '0; ifc.req_addr1 = '0;
        ifc.req_wdata0 = '0; ifc.req_wdata1 = '0;

        // Reset values, then ten idle cycles with no requests.
        repeat (3) @(negedge clk);
        chk("rst_rsp_rdata", ifa.rsp_rdata, 32'd0);
        chk("rst_mem_address", ifa.mem_address, 32'd0);
        chk("rst_mem_write_data", ifa.mem_write_data, 32'd0);
        chk("rst_rsp_err", 32'(ifa.rsp_err), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_req_ready", 32'(ifa.req_ready), 32'd0);
            chk("idle_mem_read", 32'(ifa.mem_read), 32'd0);
            chk("idle_mem_write", 32'(ifa.mem_write), 32'd0);
            chk("idle_rsp_valid", 32'(ifa.rsp_valid), 32'd0);
        end

        // Single transfers on dut_a, checked through the scoreboard.
        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
        end
        chk("word2_dead", mem_a[2], 32'h0000_DEAD);
        chk("word0_untouched", mem_a[0], 32'd0);

        // Both ports loading continuously: grants must alternate.
        @(negedge clk);
        ifa.req_write = 2'b00;
        ifa.req_addr0 = 32'h8;
        ifa.req_addr1 = 32'h10;
        ifa.req_valid = 2'b11;
        exp_port = (last_port == 0) ? 1 : 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            #1;
            while (ifa.req_ready == 2'b00 && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("rr_grant", 32'(ifa.req_ready), (exp_port == 1) ? 32'd2 : 32'd1);
            sb.push_back('{rsp: (exp_port == 1) ? 2'b10 : 2'b01, err: 1'b0,
                           rdata: (exp_port == 1) ? 32'h1234_5678 : 32'h0000_DEAD});
            exp_port = 1 - exp_port;
            @(negedge clk);
            if (k == 3) ifa.req_valid = 2'b00;
        end
        wait_sb_empty();

        // Three-cycle access: one write strobe, response four cycles after the handshake.
        b_xfer(1'b1, 32'h20, 32'h0000_BEEF, rd_cnt, wr_cnt, wr_at, rsp_at, rdata, err);
        chk("b_store_wr_cnt", 32'(wr_cnt), 32'd1);
        chk("b_store_wr_at", 32'(wr_at), 32'd3);
        chk("b_store_rd_cnt", 32'(rd_cnt), 32'd0);
        chk("b_store_rsp_at", 32'(rsp_at), 32'd4);
        chk("b_store_rdata", rdata, 32'd0);
        chk("b_mem_word8", mem_b[8], 32'h0000_BEEF);
        b_xfer(1'b0, 32'h20, 32'h0, rd_cnt, wr_cnt, wr_at, rsp_at, rdata, err);
        chk("b_load_rd_cnt", 32'(rd_cnt), 32'd3);
        chk("b_load_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("b_load_rsp_at", 32'(rsp_at), 32'd4);
        chk("b_load_rdata", rdata, 32'h0000_BEEF);
        chk("b_load_err", 32'(err), 32'd0);

        // Fixed priority: port 0 wins every tie.
        @(negedge clk);
        ifb.req_write = 2'b00;
        ifb.req_addr0 = 32'h20;
        ifb.req_addr1 = 32'h24;
        ifb.req_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            #1;
            while (ifb.req_ready == 2'b00 && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("fixed_grant", 32'(ifb.req_ready), 32'd1);
            @(negedge clk);
            if (k == 2) ifb.req_valid = 2'b00;
        end
        repeat (6) @(negedge clk);

        // Reset during the first ACCESS cycle of a two-cycle store.
        @(negedge clk);
        ifc.req_write = 2'b01;
        ifc.req_addr0 = 32'hC;
        ifc.req_wdata0 = 32'h0000_0077;
        ifc.req_valid = 2'b01;
        #1;
        chk("c_ready", 32'(ifc.req_ready), 32'd1);
        @(posedge clk);
        #1;
        ifc.req_valid = 2'b00;
        @(negedge clk);
        chk("c_first_cycle_no_write", 32'(ifc.mem_write), 32'd0);
        rst = 1'b1;
        #1;
        chk("c_rst_mem_write", 32'(ifc.mem_write), 32'd0);
        chk("c_rst_mem_read", 32'(ifc.mem_read), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rsp_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ifc.rsp_valid != 2'b00) rsp_seen++;
        end
        chk("c_no_rsp_after_abort", 32'(rsp_seen), 32'd0);
        chk("c_word3_unchanged", mem_c[3], 32'd0);
        chk("c_state_idle", 32'(dut_c.state), 32'(ST_IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
